cp0_unit: RTL and testbench
===========================

# cp0_unit

Coprocessor-0 responder for the multi-cycle MIPS54 core: it holds Status, Cause, EPC and an optional Count/Compare timer. It serves `mfc0`/`mtc0` accesses, records exception entry, restores state on `eret`, and drives the exception/return target address back to the CPU's PC multiplexer. It sits beside the CPU top level and connects one-to-one to the CPU's `cpu_cp0_*` outputs and `cp0_cpu_*` inputs.

## Interface
- `EXC_VECTOR`, 32'h0040_0004, exception handler entry address.
- `STATUS_RESET`, 32'h0000_000F, Status value after reset.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `mfc0`  in  1  read strobe for the register selected by `rd`.
- `mtc0`  in  1  write strobe: `wdata` is written to the register selected by `rd`.
- `pc`  in  32  PC of the faulting instruction; captured into EPC on exception.
- `rd`  in  5  CP0 register number.
- `wdata`  in  32  `mtc0` write data.
- `exception`  in  1  exception-entry strobe, one cycle.
- `eret`  in  1  exception-return strobe, one cycle.
- `cause`  in  5  ExcCode for this exception: 8 = syscall, 9 = break, 13 = trap.
- `rdata`  out  32  `mfc0` read data.
- `status`  out  32  current Status register.
- `exc_addr`  out  32  PC target for exception entry or `eret`.
- `timer_int`  out  1  timer interrupt pending.

## Operation
- **Registers.** Status (rd 12), Cause (rd 13), EPC (rd 14). With the timer compiled in, Count (rd 9) and Compare (rd 11) are added.
- **Unimplemented `rd`.** Other register numbers read 0; writes to them are ignored.
- **`rdata`.** Equals the selected register when `mfc0`=1, otherwise 0. It is combinational.
- **Exception entry** (`exception`=1):
  - Status ← {Status[26:0], 5'b0}, which masks interrupt and exception enables.
  - Cause[6:2] ← `cause`; all other Cause bits are cleared, except Cause[15].
  - EPC ← `pc`.
- **`eret`** (`eret`=1): Status ← {5'b0, Status[31:5]}. EPC and Cause are unchanged.
- **`exc_addr`.** Equals EPC when `eret`=1, otherwise `EXC_VECTOR`. It is combinational.
- **Priority for same-cycle strobes:** `exception` > `eret` > `mtc0`. A lower-priority strobe is ignored entirely in that cycle.
- **`mfc0` alongside a write.** Concurrent `mfc0` returns the pre-edge register value.
- **`mtc0` to Cause.** Only bits [9:8] (software interrupts) are written; all other bits keep their values.
- **Cause[15].** Always mirrors `timer_int`.
- **Reset.** Status = `STATUS_RESET`; Cause = 0; EPC = 0; Count = 0; Compare = 0; `timer_int` = 0.
- **Reset values of outputs:** `rdata` = 0 (unless `mfc0` is high), `status` = `STATUS_RESET`, `exc_addr` = `EXC_VECTOR`.
- **Timer** (when compiled in):
  - Count increments by 1 every second `clk` cycle, using an internal toggle bit that resets to 0. Count wraps from 32'hFFFF_FFFF to 0.
  - `timer_int` is set when Count == Compare, Compare ≠ 0, and the toggle bit makes Count advance in the same cycle.
  - `timer_int` stays set until Compare is written by `mtc0`.
  - `mtc0` to Count loads `wdata` and clears the toggle bit.
  - A Compare write in the same cycle as a match clears `timer_int`; the clear wins.

## Timing
- **Register writes.** All writes (`mtc0`, exception entry, `eret`, timer) take effect at the rising edge where the strobe is high. They are visible on `status`/`rdata` in the following cycle.
- **Combinational outputs.** `rdata` and `exc_addr` have zero-cycle latency. The CPU samples `exc_addr` into PC in the same cycle it asserts `exception`/`eret`.
- **Strobe width.** Strobes are single-cycle. A strobe held high for N cycles acts N times; for example, `exception` held for 2 cycles shifts Status by 10.
- **Asynchronous reset.** Asserting `reset` low mid-operation clears all state immediately, regardless of `clk`. Release is sampled at the next rising edge.

## Configuration
- Macro `CP0_TIMER_EN`.
- **Defined:** Count/Compare and `timer_int` are implemented as described above.
- **Undefined:**
  - No Count/Compare storage is built, and rd 9/11 read 0.
  - `timer_int` is tied to 0, and Cause[15] is always 0.
  - Status, Cause and EPC behaviour is unchanged.

## Test plan
- **Reset.** Hold `reset`=0, then release. Required: `status` = 32'h0000_000F, `exc_addr` = 32'h0040_0004, and `mfc0` at rd 14 reads 0.
- **Exception entry.** Apply `exception`=1, `cause`=8, `pc`=32'h0040_0100. Required: next cycle `status` = 32'h0000_01E0, Cause reads 32'h0000_0020, EPC reads 32'h0040_0100, and `exc_addr` = 32'h0040_0004 during the strobe.
- **eret.** After the exception above, apply `eret`=1. Required: `exc_addr` = 32'h0040_0100 during the strobe, and `status` = 32'h0000_000F next cycle.
- **Same-cycle priority.** Apply `exception`, `eret` and `mtc0` (rd 12, `wdata`=32'h0) together. Required: only exception entry occurs and Status = 32'h0000_01E0.
- **Cause write mask.** `mtc0` rd 13 with `wdata` = 32'hFFFF_FFFF. Required: Cause reads 32'h0000_0300.
- **Timer** (`CP0_TIMER_EN`). `mtc0` Compare = 5 and Count = 0. Required: `timer_int` rises after Count reaches 5 (about 10 cycles) and Cause[15] = 1. A subsequent `mtc0` Compare = 5 clears `timer_int` next cycle. Without the macro, `timer_int` stays 0 throughout.

Source files
------------

// File: rtl/cp0_unit.sv
// Coprocessor-0 responder: Status/Cause/EPC with mfc0/mtc0, exception entry and eret.
// Optional Count/Compare timer is built when CP0_TIMER_EN is defined.
module cp0_unit #(
    parameter logic [31:0] EXC_VECTOR   = 32'h0040_0004,
    parameter logic [31:0] STATUS_RESET = 32'h0000_000F
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mfc0,
    input  logic        mtc0,
    input  logic [31:0] pc,
    input  logic [4:0]  rd,
    input  logic [31:0] wdata,
    input  logic        exception,
    input  logic        eret,
    input  logic [4:0]  cause,
    output logic [31:0] rdata,
    output logic [31:0] status,
    output logic [31:0] exc_addr,
    output logic        timer_int
);
    localparam logic [4:0] RD_COUNT   = 5'd9;
    localparam logic [4:0] RD_COMPARE = 5'd11;
    localparam logic [4:0] RD_STATUS  = 5'd12;
    localparam logic [4:0] RD_CAUSE   = 5'd13;
    localparam logic [4:0] RD_EPC     = 5'd14;

    logic [31:0] r_status;
    logic [31:0] r_epc;
    logic [4:0]  r_exc_code;
    logic [1:0]  r_ip_sw;
    logic        w_wr_en;
    logic [31:0] w_cause;

    // mtc0 is dropped whenever exception or eret is present in the same cycle
    assign w_wr_en = mtc0 & ~exception & ~eret;

    // Only ExcCode, software interrupt bits and the timer mirror are stored/visible
    assign w_cause = {16'b0, timer_int, 5'b0, r_ip_sw, 1'b0, r_exc_code, 2'b0};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_status   <= STATUS_RESET;
            r_epc      <= '0;
            r_exc_code <= '0;
            r_ip_sw    <= '0;
        end else if (exception) begin
            r_status   <= {r_status[26:0], 5'b0};
            r_exc_code <= cause;
            r_ip_sw    <= '0;
            r_epc      <= pc;
        end else if (eret) begin
            r_status   <= {5'b0, r_status[31:5]};
        end else if (w_wr_en) begin
            case (rd)
                RD_STATUS: r_status <= wdata;
                RD_CAUSE:  r_ip_sw  <= wdata[9:8];
                RD_EPC:    r_epc    <= wdata;
                default: ;
            endcase
        end
    end

`ifdef CP0_TIMER_EN
    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        r_tick;
    logic        r_timer_int;
    logic        w_count_wr;
    logic        w_compare_wr;

    assign w_count_wr   = w_wr_en && (rd == RD_COUNT);
    assign w_compare_wr = w_wr_en && (rd == RD_COMPARE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count     <= '0;
            r_compare   <= '0;
            r_tick      <= 1'b0;
            r_timer_int <= 1'b0;
        end else begin
            if (w_count_wr) begin
                r_count <= wdata;
                r_tick  <= 1'b0;
            end else begin
                r_tick <= ~r_tick;
                if (r_tick)
                    r_count <= r_count + 32'd1;
            end
            if (w_compare_wr)
                r_compare <= wdata;
            // Compare write acknowledges the interrupt and beats a simultaneous match
            if (w_compare_wr)
                r_timer_int <= 1'b0;
            else if (r_tick && (r_count == r_compare) && (r_compare != 32'd0))
                r_timer_int <= 1'b1;
        end
    end

    assign timer_int = r_timer_int;
`else
    assign timer_int = 1'b0;
`endif

    always_comb begin
        rdata = '0;
        if (mfc0) begin
            case (rd)
                RD_STATUS:  rdata = r_status;
                RD_CAUSE:   rdata = w_cause;
                RD_EPC:     rdata = r_epc;
`ifdef CP0_TIMER_EN
                RD_COUNT:   rdata = r_count;
                RD_COMPARE: rdata = r_compare;
`endif
                default:    rdata = '0;
            endcase
        end
    end

    assign status   = r_status;
    assign exc_addr = eret ? r_epc : EXC_VECTOR;

endmodule

// File: tb/tb_cp0_unit.sv
// Bench for cp0_unit: directed steps followed by random strobes, checked against
// a register-level reference model of CP0 kept in the bench.
module tb_cp0_unit;
    localparam logic [31:0] EXC_VEC = 32'h0040_0004;
    localparam logic [31:0] ST_RST  = 32'h0000_000F;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mfc0 = 1'b0, mtc0 = 1'b0, exception = 1'b0, eret = 1'b0;
    logic [31:0] pc = '0, wdata = '0;
    logic [4:0]  rd = '0, cause = '0;
    logic [31:0] rdata, status, exc_addr;
    logic        timer_int;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    logic [31:0] m_status, m_cause, m_epc, m_count, m_compare;
    logic        m_half, m_tint;
    logic [31:0] last_exc_addr, last_rdata;

    cp0_unit dut (
        .clk(clk), .reset(rst_n), .mfc0(mfc0), .mtc0(mtc0), .pc(pc), .rd(rd),
        .wdata(wdata), .exception(exception), .eret(eret), .cause(cause),
        .rdata(rdata), .status(status), .exc_addr(exc_addr), .timer_int(timer_int)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_status = ST_RST; m_cause = '0; m_epc = '0;
        m_count = '0; m_compare = '0; m_half = 1'b0; m_tint = 1'b0;
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] r, input logic en);
        logic [31:0] v;
        v = '0;
        if (en) begin
            if (r == 5'd12) v = m_status;
            else if (r == 5'd13) v = m_cause | (m_tint ? 32'h0000_8000 : 32'h0);
            else if (r == 5'd14) v = m_epc;
`ifdef CP0_TIMER_EN
            else if (r == 5'd9) v = m_count;
            else if (r == 5'd11) v = m_compare;
`endif
        end
        return v;
    endfunction

    // One clock cycle: drive, check pre-edge outputs, advance the model across the edge.
    task automatic step(input logic e, input logic er, input logic wr, input logic rdn,
                        input logic [4:0] r, input logic [31:0] w, input logic [31:0] p,
                        input logic [4:0] c);
        logic [31:0] n_status, n_cause, n_epc, n_count, n_compare;
        logic        n_half, n_tint, cnt_wr, cmp_wr;
        @(negedge clk);
        exception = e; eret = er; mtc0 = wr; mfc0 = rdn; rd = r; wdata = w; pc = p; cause = c;
        #1;
        last_exc_addr = exc_addr;
        last_rdata    = rdata;
        chk("rdata", rdata, m_read(r, rdn));
        chk("exc_addr", exc_addr, er ? m_epc : EXC_VEC);
        chk("status", status, m_status);
        chk("timer_int", {31'b0, timer_int}, {31'b0, m_tint});

        n_status = m_status; n_cause = m_cause; n_epc = m_epc;
        n_count = m_count; n_compare = m_compare; n_half = m_half; n_tint = m_tint;
        cnt_wr = 1'b0; cmp_wr = 1'b0;
        if (e) begin
            n_status = m_status << 5;
            n_cause  = {27'b0, c} << 2;
            n_epc    = p;
        end else if (er) begin
            n_status = m_status >> 5;
        end else if (wr) begin
            if (r == 5'd12) n_status = w;
            else if (r == 5'd13) n_cause = (m_cause & ~32'h300) | (w & 32'h300);
            else if (r == 5'd14) n_epc = w;
            else if (r == 5'd9) cnt_wr = 1'b1;
            else if (r == 5'd11) cmp_wr = 1'b1;
        end
`ifdef CP0_TIMER_EN
        if (cnt_wr) begin
            n_count = w; n_half = 1'b0;
        end else begin
            n_half = ~m_half;
            if (m_half) n_count = m_count + 1;
        end
        if (cmp_wr) begin
            n_compare = w; n_tint = 1'b0;
        end else if (m_half && m_count == m_compare && m_compare != 0) begin
            n_tint = 1'b1;
        end
`endif
        @(posedge clk);
        #1;
        m_status = n_status; m_cause = n_cause; m_epc = n_epc;
        m_count = n_count; m_compare = n_compare; m_half = n_half; m_tint = n_tint;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 5'd0);
    endtask

    task automatic rd_reg(input logic [4:0] r);
        step(0, 0, 0, 1, r, 32'h0, 32'h0, 5'd0);
    endtask

    initial begin
        model_reset();
        #23;
        @(negedge clk);
        rst_n = 1'b1;

        // reset values
        chk("rst_status", status, 32'h0000_000F);
        chk("rst_exc_addr", exc_addr, 32'h0040_0004);
        rd_reg(5'd14);
        chk("rst_epc", last_rdata, 32'h0);

        // Cause write mask
        step(0, 0, 1, 0, 5'd13, 32'hFFFF_FFFF, 32'h0, 5'd0);
        rd_reg(5'd13);
        chk("cause_mask", last_rdata, 32'h0000_0300);

        // exception entry
        step(1, 0, 0, 0, 5'd0, 32'h0, 32'h0040_0100, 5'd8);
        chk("exc_vec_during", last_exc_addr, 32'h0040_0004);
        chk("exc_status", status, 32'h0000_01E0);
        rd_reg(5'd13);
        chk("exc_cause", last_rdata, 32'h0000_0020);
        rd_reg(5'd14);
        chk("exc_epc", last_rdata, 32'h0040_0100);

        // eret
        step(0, 1, 0, 0, 5'd0, 32'h0, 32'h0, 5'd0);
        chk("eret_addr_during", last_exc_addr, 32'h0040_0100);
        chk("eret_status", status, 32'h0000_000F);

        // same-cycle priority
        step(1, 1, 1, 0, 5'd12, 32'h0, 32'h0040_0200, 5'd9);
        chk("prio_status", status, 32'h0000_01E0);
        rd_reg(5'd14);
        chk("prio_epc", last_rdata, 32'h0040_0200);

        // mfc0 concurrent with mtc0 returns old value; exception held two cycles
        step(0, 0, 1, 1, 5'd12, 32'h0000_000F, 32'h0, 5'd0);
        chk("mfc0_old", last_rdata, 32'h0000_01E0);
        step(1, 0, 0, 0, 5'd0, 32'h0, 32'h0040_0300, 5'd13);
        step(1, 0, 0, 0, 5'd0, 32'h0, 32'h0040_0304, 5'd13);
        chk("exc_x2_status", status, 32'h0000_3C00);
        rd_reg(5'd10);
        chk("unimpl_rd", last_rdata, 32'h0);

        // timer
        step(0, 0, 1, 0, 5'd11, 32'd5, 32'h0, 5'd0);
        step(0, 0, 1, 0, 5'd9, 32'd0, 32'h0, 5'd0);
        for (int i = 0; i < 40; i++) begin
            if (timer_int) break;
            idle();
        end
`ifdef CP0_TIMER_EN
        chk("timer_rise", {31'b0, timer_int}, 32'h1);
        rd_reg(5'd13);
        chk("cause15", {31'b0, last_rdata[15]}, 32'h1);
        step(0, 0, 1, 0, 5'd11, 32'd5, 32'h0, 5'd0);
        chk("timer_clear", {31'b0, timer_int}, 32'h0);
`else
        chk("timer_off", {31'b0, timer_int}, 32'h0);
        rd_reg(5'd9);
        chk("count_off", last_rdata, 32'h0);
`endif

        // random traffic
        for (int i = 0; i < 600; i++) begin
            logic [4:0] r;
            case ($urandom_range(0, 5))
                0: r = 5'd9;
                1: r = 5'd11;
                2: r = 5'd12;
                3: r = 5'd13;
                4: r = 5'd14;
                default: r = 5'($urandom);
            endcase
            step($urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, r,
                 (r == 5'd11 || r == 5'd9) ? 32'($urandom_range(0, 12)) : $urandom,
                 $urandom, 5'($urandom));
        end

        // asynchronous reset mid-cycle
        @(negedge clk);
        exception = 1'b0; eret = 1'b0; mtc0 = 1'b0; mfc0 = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_status", status, ST_RST);
        chk("arst_exc_addr", exc_addr, EXC_VEC);
        chk("arst_timer", {31'b0, timer_int}, 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        rd_reg(5'd13);
        rd_reg(5'd14);
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
